txt_rom_stream: RTL and testbench

- Parametrised multi-message text ROM for the snake menu/HUD renderer.
- Holds NUM_TXT fixed strings; txt_sel picks the active string.
- Random-access port: registered 1-cycle lookup by character index, same timing as the existing per-screen text ROMs.
- Stream port: on a start pulse, emits the selected string character by character over a valid/ready handshake, for the char-buffer writer.

---
 rtl/txt_rom_pkg.sv | 56 +++++
 rtl/txt_rom_lookup.sv | 36 +++
 rtl/txt_rom_stream.sv | 117 +++++++++++
 tb/tb_txt_rom_stream.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/txt_rom_pkg.sv
// Shared constants for the menu/HUD text ROM: string table, lengths, ids and stream FSM states.
package txt_rom_pkg;

  localparam int NUM_TXT_DEF = 4;
  localparam int MAX_LEN_DEF = 32;
  localparam int DSEL_W      = $clog2(NUM_TXT_DEF);
  localparam logic [6:0] CHAR_SPACE = 7'h20;

  typedef enum logic [1:0] {
    TXT_ONE_PLAYER = 2'd0,
    TXT_TWO_PLAYER = 2'd1,
    TXT_GAME_OVER  = 2'd2,
    TXT_WINNER     = 2'd3
  } txt_id_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    FIN  = 2'd3
  } txt_state_t;

  // One row per string, left-justified: character i sits in byte [MAX_LEN_DEF-1-i].
  typedef logic [MAX_LEN_DEF-1:0][7:0] txt_row_t;

  function automatic logic [7:0] clamp_len(input int len);
    if (len > MAX_LEN_DEF) return 8'(MAX_LEN_DEF);
    else return 8'(len);
  endfunction

  localparam logic [7:0] TXT_LEN [NUM_TXT_DEF] = '{
    clamp_len(16), clamp_len(14), clamp_len(10), clamp_len(13)
  };

  localparam txt_row_t TXT_DATA [NUM_TXT_DEF] = '{
    {"gra jednoosobowa", {16{8'h20}}},
    {"gra dwuosobowa",   {18{8'h20}}},
    {"koniec gry",       {22{8'h20}}},
    {"wygral gracz ",    {19{8'h20}}}
  };

  // Effective length of a string, zero for an unknown selector, clamped to max_len.
  function automatic logic [7:0] txt_len_of(input int sel, input int max_len);
    logic [7:0] len;
    if (sel < 0 || sel >= NUM_TXT_DEF) len = 8'd0;
    else len = TXT_LEN[sel[DSEL_W-1:0]];
    if (int'(len) > max_len) len = 8'(max_len);
    return len;
  endfunction

  function automatic logic [6:0] to_upper(input logic [6:0] c);
    if (c >= 7'h61 && c <= 7'h7A) return c - 7'h20;
    else return c;
  endfunction

endpackage

// File: rtl/txt_rom_lookup.sv
// Combinational (sel, idx) -> character lookup with range check.
// TXT_UPPERCASE_EN maps a-z to A-Z before the code leaves this block.
module txt_rom_lookup
  import txt_rom_pkg::*;
#(
  parameter int NUM_TXT = NUM_TXT_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int CHAR_W  = 7,
  parameter int SEL_W   = (NUM_TXT > 1) ? $clog2(NUM_TXT) : 1
) (
  input  logic [SEL_W-1:0]  sel,
  input  logic [7:0]        idx,
  output logic [CHAR_W-1:0] code
);

  localparam int POS_W = $clog2(MAX_LEN_DEF);

  logic [7:0]       len;
  logic [6:0]       raw;
  logic [POS_W-1:0] pos;
  logic             in_range;

  always_comb begin
    len      = txt_len_of(int'(sel), MAX_LEN);
    in_range = (int'(sel) < NUM_TXT) && (int'(idx) < int'(len));
    pos      = POS_W'(MAX_LEN_DEF - 1 - int'(idx));
    if (in_range) raw = TXT_DATA[DSEL_W'(sel)][pos][6:0];
    else raw = CHAR_SPACE;
`ifdef TXT_UPPERCASE_EN
    code = CHAR_W'(to_upper(raw));
`else
    code = CHAR_W'(raw);
`endif
  end

endmodule

// File: rtl/txt_rom_stream.sv
// Multi-message text ROM with a registered random-access port and a valid/ready character stream.
// Optional TXT_UPPERCASE_EN (in txt_rom_lookup) upper-cases both outputs.
module txt_rom_stream
  import txt_rom_pkg::*;
#(
  parameter int NUM_TXT = NUM_TXT_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int CHAR_W  = 7,
  parameter int SEL_W   = (NUM_TXT > 1) ? $clog2(NUM_TXT) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SEL_W-1:0]  txt_sel,
  input  logic [7:0]        char_xy,
  output logic [CHAR_W-1:0] char_code,
  input  logic              start,
  output logic              busy,
  output logic [CHAR_W-1:0] stream_char,
  output logic [7:0]        stream_idx,
  output logic              stream_valid,
  input  logic              stream_ready,
  output logic              stream_last,
  output logic              done
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_LOAD = LOAD;
  localparam logic [1:0] ST_SEND = SEND;
  localparam logic [1:0] ST_FIN  = FIN;

  logic [1:0]        state;
  logic [SEL_W-1:0]  sel_q;
  logic [7:0]        idx;
  logic [CHAR_W-1:0] ra_code;
  logic [CHAR_W-1:0] st_code;
  logic [7:0]        start_len;
  logic [7:0]        cur_len;
  logic              start_ok;

  txt_rom_lookup #(.NUM_TXT(NUM_TXT), .MAX_LEN(MAX_LEN), .CHAR_W(CHAR_W), .SEL_W(SEL_W)) u_ra_lookup (
    .sel  (txt_sel),
    .idx  (char_xy),
    .code (ra_code)
  );

  txt_rom_lookup #(.NUM_TXT(NUM_TXT), .MAX_LEN(MAX_LEN), .CHAR_W(CHAR_W), .SEL_W(SEL_W)) u_st_lookup (
    .sel  (sel_q),
    .idx  (idx),
    .code (st_code)
  );

  always_comb begin
    start_len = txt_len_of(int'(txt_sel), MAX_LEN);
    start_ok  = (int'(txt_sel) < NUM_TXT) && (start_len != 8'd0);
    cur_len   = txt_len_of(int'(sel_q), MAX_LEN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) char_code <= CHAR_W'(CHAR_SPACE);
    else char_code <= ra_code;
  end

  // Stream FSM: LOAD registers one character, SEND holds it until the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      sel_q        <= '0;
      idx          <= 8'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      stream_valid <= 1'b0;
      stream_last  <= 1'b0;
      stream_idx   <= 8'd0;
      stream_char  <= CHAR_W'(CHAR_SPACE);
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            sel_q <= txt_sel;
            idx   <= 8'd0;
            if (start_ok) begin
              state <= ST_LOAD;
              busy  <= 1'b1;
            end else begin
              state <= ST_FIN;
              done  <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          stream_char  <= st_code;
          stream_idx   <= idx;
          stream_last  <= (idx == cur_len - 8'd1);
          stream_valid <= 1'b1;
          state        <= ST_SEND;
        end
        ST_SEND: begin
          if (stream_ready) begin
            stream_valid <= 1'b0;
            if (stream_last) begin
              state <= ST_FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              idx   <= idx + 8'd1;
              state <= ST_LOAD;
            end
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_txt_rom_stream.sv
// Randomised self-checking bench for txt_rom_stream against a string-level reference model.
`timescale 1ns/1ps
module tb_txt_rom_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] txt_sel = 2'd0;
  logic [7:0] char_xy = 8'd0;
  logic       start = 1'b0;
  logic       stream_ready = 1'b0;
  logic [6:0] char_code;
  logic [6:0] stream_char;
  logic [7:0] stream_idx;
  logic       busy, stream_valid, stream_last, done;

`ifdef TXT_UPPERCASE_EN
  localparam int J_EXP = 32'h4A;
`else
  localparam int J_EXP = 32'h6A;
`endif

  int checks = 0;
  int errors = 0;
  string txt [4] = '{"gra jednoosobowa", "gra dwuosobowa", "koniec gry", "wygral gracz "};

  int m_sel = 0;
  int m_idx = 0;
  int hs_count = 0;
  int done_count = 0;
  int ra_exp = 0;
  bit ra_armed = 1'b0;
  bit done_due = 1'b0;
  bit prev_wait = 1'b0;

  always #5 clk = ~clk;

  txt_rom_stream dut (
    .clk          (clk),
    .rst          (rst),
    .txt_sel      (txt_sel),
    .char_xy      (char_xy),
    .char_code    (char_code),
    .start        (start),
    .busy         (busy),
    .stream_char  (stream_char),
    .stream_idx   (stream_idx),
    .stream_valid (stream_valid),
    .stream_ready (stream_ready),
    .stream_last  (stream_last),
    .done         (done)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_char(input int s, input int i);
    int c;
    if (s < 0 || s >= 4) return 32'h20;
    if (i >= txt[s].len()) return 32'h20;
    c = int'(txt[s][i]);
`ifdef TXT_UPPERCASE_EN
    if (c >= 32'h61 && c <= 32'h7A) c = c - 32'h20;
`endif
    return c;
  endfunction

  // Continuous monitor: lookup pipeline, stream contents, done/busy relationship.
  always @(negedge clk) begin
    if (rst) begin
      ra_armed  = 1'b0;
      m_idx     = 0;
      done_due  = 1'b0;
      prev_wait = 1'b0;
    end else begin
      if (ra_armed) check_eq("char_code", int'(char_code), ra_exp);
      ra_exp   = model_char(int'(txt_sel), int'(char_xy));
      ra_armed = 1'b1;
      check_eq("done", int'(done), int'(done_due));
      if (done) done_count++;
      if (done_due) check_eq("busy_at_done", int'(busy), 0);
      if (prev_wait) check_eq("valid_hold", int'(stream_valid), 1);
      done_due = 1'b0;
      if (stream_valid) begin
        check_eq("stream_char", int'(stream_char), model_char(m_sel, m_idx));
        check_eq("stream_idx", int'(stream_idx), m_idx);
        check_eq("stream_last", int'(stream_last), int'(m_idx == txt[m_sel].len() - 1));
        check_eq("busy_in_send", int'(busy), 1);
        if (stream_ready) begin
          hs_count++;
          if (stream_last) begin
            done_due = 1'b1;
            m_idx    = 0;
          end else begin
            m_idx++;
          end
        end
      end
      prev_wait = stream_valid && !stream_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_outputs(input string when);
    check_eq({when, "_char_code"}, int'(char_code), 32'h20);
    check_eq({when, "_stream_char"}, int'(stream_char), 32'h20);
    check_eq({when, "_stream_idx"}, int'(stream_idx), 0);
    check_eq({when, "_stream_valid"}, int'(stream_valid), 0);
    check_eq({when, "_stream_last"}, int'(stream_last), 0);
    check_eq({when, "_busy"}, int'(busy), 0);
    check_eq({when, "_done"}, int'(done), 0);
  endtask

  task automatic lookup(input string tag, input int s, input int x, input int exp);
    tick();
    txt_sel = 2'(s);
    char_xy = 8'(x);
    @(negedge clk);
    @(negedge clk);
    check_eq(tag, int'(char_code), exp);
  endtask

  task automatic do_start(input int sel);
    tick();
    txt_sel = 2'(sel);
    start   = 1'b1;
    m_sel   = sel;
    tick();
    start   = 1'b0;
  endtask

  task automatic run_stream(input int budget, input bit rand_ready);
    int d0;
    int n;
    d0 = done_count;
    n  = 0;
    while (done_count == d0 && n < budget) begin
      tick();
      n++;
      stream_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      txt_sel = 2'($urandom_range(0, 3));
      char_xy = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 17));
    end
    if (done_count == d0) check_eq("stream_timeout", 0, 1);
  endtask

  initial begin
    int h0;
    int d0;
    int n;
    int s;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    tick();
    rst = 1'b0;

    lookup("lookup_j", 0, 4, J_EXP);
    lookup("lookup_len_edge", 2, 10, 32'h20);
    lookup("lookup_ff", 3, 255, 32'h20);
    lookup("lookup_last_k", 2, 9, model_char(2, 9));

    // Full stream with the consumer always ready.
    stream_ready = 1'b1;
    h0 = hs_count;
    d0 = done_count;
    do_start(2);
    run_stream(100, 1'b0);
    check_eq("koniec_handshakes", hs_count - h0, 10);
    check_eq("koniec_done_once", done_count - d0, 1);

    // Stall on idx 4 ("j"), with a stray start and select change during the stall.
    h0 = hs_count;
    do_start(0);
    n = 0;
    while (!(busy && !stream_valid && stream_idx == 8'd3) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check_eq("stall_timeout", 0, 1);
    stream_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 1) begin
        start   = 1'b1;
        txt_sel = 2'd1;
      end else if (k == 2) begin
        start   = 1'b0;
        txt_sel = 2'd3;
      end
      @(negedge clk);
      check_eq("stall_char", int'(stream_char), J_EXP);
      check_eq("stall_valid", int'(stream_valid), 1);
    end
    tick();
    start = 1'b0;
    stream_ready = 1'b1;
    run_stream(200, 1'b0);
    check_eq("stall_handshakes", hs_count - h0, 16);

    // Asynchronous reset while idx 5 of string 1 is on offer.
    do_start(1);
    n = 0;
    while (!(stream_valid && stream_idx == 8'd5) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check_eq("reset_wait_timeout", 0, 1);
    #1 rst = 1'b1;
    #1 check_reset_outputs("midreset");
    d0 = done_count;
    repeat (3) @(negedge clk);
    check_eq("midreset_no_done", int'(done), 0);
    tick();
    rst = 1'b0;
    h0 = hs_count;
    do_start(1);
    run_stream(200, 1'b0);
    check_eq("after_reset_handshakes", hs_count - h0, 14);
    check_eq("after_reset_done_once", done_count - d0, 1);

    // Random strings, random back-pressure, random lookups every cycle.
    for (int r = 0; r < 8; r++) begin
      s  = int'($urandom_range(0, 3));
      h0 = hs_count;
      do_start(s);
      run_stream(400, 1'b1);
      check_eq("rand_handshakes", hs_count - h0, txt[s].len());
    end

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
